// File: rtl/muldiv_pkg.sv
// Shared definitions for the M-extension issue block.
// Holds the RV32M funct3 encodings, the issue FSM state encoding, the
// default operand/tag widths, and small helpers that classify funct3.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RDW_DEF  = 5;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MUL_WAIT = 2'd1,
    DIV_WAIT = 2'd2,
    RESP     = 2'd3
  } state_e;

  function automatic logic isMul(input logic [2:0] f3);
    return (f3 == F3_MUL) || (f3 == F3_MULH) || (f3 == F3_MULHSU) || (f3 == F3_MULHU);
  endfunction

  function automatic logic isDiv(input logic [2:0] f3);
    return (f3 == F3_DIV) || (f3 == F3_DIVU) || (f3 == F3_REM) || (f3 == F3_REMU);
  endfunction

endpackage

// File: rtl/muldiv_special.sv
// Special-case detector for division ops.
// Recognises the two cases the divider is never asked to handle:
// divide-by-zero and signed overflow (most-negative / -1), and produces
// the architecturally defined result so the issue block can skip the unit.
// Ports:
//   funct3_i  - RV32M funct3 of the offered op
//   rs1_i     - dividend
//   rs2_i     - divisor
//   bypass_o  - 1 when the op must not go to the divider
//   result_o  - result to return when bypass_o is 1 (0 otherwise)
module muldiv_special
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] rs1_i,
  input  logic [XLEN-1:0] rs2_i,
  output logic            bypass_o,
  output logic [XLEN-1:0] result_o
);

  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};

  logic divZero;
  logic signedOvf;

  assign divZero   = (rs2_i == '0);
  assign signedOvf = (rs1_i == MinNeg) && (rs2_i == '1);

  // Divide-by-zero wins over overflow: with rs2=0 the overflow pattern
  // cannot match anyway, but the ordering keeps the intent explicit.
  always_comb begin
    bypass_o = 1'b0;
    result_o = '0;
    if (isDiv(funct3_i)) begin
      if (divZero) begin
        bypass_o = 1'b1;
        result_o = ((funct3_i == F3_REM) || (funct3_i == F3_REMU)) ? rs1_i : '1;
      end else if (signedOvf && ((funct3_i == F3_DIV) || (funct3_i == F3_REM))) begin
        bypass_o = 1'b1;
        result_o = (funct3_i == F3_DIV) ? MinNeg : '0;
      end
    end
  end

endmodule

// File: rtl/muldiv_issue.sv
// Issue/sequencing block for RV32M multiply and divide ops.
// Accepts one op at a time from execute, latches its operands, starts the
// external multiplier or divider (or short-circuits special divisions),
// waits for the unit, then holds the result until writeback takes it.
// Ports:
//   clk, rst_n                 - clock, synchronous active-low reset
//   req_*                      - op offer from execute (valid/ready)
//   flush                      - kill whatever is in flight
//   mul_en/op/a/b, mul_done/res - external multiplier interface
//   div_en/fuct3/signed/a/b, div_done/res - external divider interface
//   rsp_*                      - result to writeback (valid/ready)
//   busy                       - high whenever an op is held
module muldiv_issue
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RDW  = RDW_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_rs1,
  input  logic [XLEN-1:0] req_rs2,
  input  logic [RDW-1:0]  req_rd,
  input  logic            flush,
  output logic            mul_en,
  output logic [1:0]      mul_op,
  output logic [XLEN-1:0] mul_a,
  output logic [XLEN-1:0] mul_b,
  input  logic            mul_done,
  input  logic [XLEN-1:0] mul_res,
  output logic            div_en,
  output logic            div_fuct3,
  output logic            div_signed,
  output logic [XLEN-1:0] div_a,
  output logic [XLEN-1:0] div_b,
  input  logic            div_done,
  input  logic [XLEN-1:0] div_res,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [XLEN-1:0] rsp_data,
  output logic [RDW-1:0]  rsp_rd,
  output logic            busy
);

  state_e          state_q, state_d;
  logic [2:0]      funct3_q, funct3_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [RDW-1:0]  rd_q, rd_d;
  logic [XLEN-1:0] rspData_q, rspData_d;

  logic            accept;
  logic            bypass;
  logic [XLEN-1:0] bypassRes;

  // Special cases are judged on the live request so a bypassed op can
  // reach RESP on the accept edge itself.
  muldiv_special #(
    .XLEN(XLEN)
  ) uSpecial (
    .funct3_i (req_funct3),
    .rs1_i    (req_rs1),
    .rs2_i    (req_rs2),
    .bypass_o (bypass),
    .result_o (bypassRes)
  );

  // A flush in IDLE withdraws ready so the handshake itself never completes.
  assign req_ready = (state_q == IDLE) && !flush;
  assign accept    = req_valid && req_ready;

  // Next-state logic; flush overrides every transition including done and
  // rsp_ready, so a flushed op can never surface a response.
  always_comb begin
    state_d   = state_q;
    funct3_d  = funct3_q;
    rs1_d     = rs1_q;
    rs2_d     = rs2_q;
    rd_d      = rd_q;
    rspData_d = rspData_q;
    if (flush) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            funct3_d = req_funct3;
            rs1_d    = req_rs1;
            rs2_d    = req_rs2;
            rd_d     = req_rd;
            if (isMul(req_funct3)) begin
              state_d = MUL_WAIT;
            end else if (bypass) begin
              state_d   = RESP;
              rspData_d = bypassRes;
            end else begin
              state_d = DIV_WAIT;
            end
          end
        end
        MUL_WAIT: begin
          if (mul_en && mul_done) begin
            state_d   = RESP;
            rspData_d = mul_res;
          end
        end
        DIV_WAIT: begin
          if (div_en && div_done) begin
            state_d   = RESP;
            rspData_d = div_res;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and operand registers; reset clears everything so no stale
  // operands or tags remain visible on the unit or response ports.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      funct3_q  <= '0;
      rs1_q     <= '0;
      rs2_q     <= '0;
      rd_q      <= '0;
      rspData_q <= '0;
    end else begin
      state_q   <= state_d;
      funct3_q  <= funct3_d;
      rs1_q     <= rs1_d;
      rs2_q     <= rs2_d;
      rd_q      <= rd_d;
      rspData_q <= rspData_d;
    end
  end

  // Divider mode bits are only meaningful while the divider is enabled,
  // so they are held low otherwise.
  assign mul_en     = (state_q == MUL_WAIT);
  assign div_en     = (state_q == DIV_WAIT);
  assign mul_op     = funct3_q[1:0];
  assign mul_a      = rs1_q;
  assign mul_b      = rs2_q;
  assign div_fuct3  = div_en && funct3_q[2] && !funct3_q[1];
  assign div_signed = div_en && funct3_q[2] && !funct3_q[0];
  assign div_a      = rs1_q;
  assign div_b      = rs2_q;
  assign rsp_valid  = (state_q == RESP);
  assign rsp_data   = rspData_q;
  assign rsp_rd     = rd_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_muldiv_issue.sv
// Directed testbench for muldiv_issue with behavioural multiplier and
// divider stubs. Expected values are hand-computed constants.
module tb_muldiv_issue;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic [31:0] req_rs1;
  logic [31:0] req_rs2;
  logic [4:0]  req_rd;
  logic        flush;
  logic        mul_en;
  logic [1:0]  mul_op;
  logic [31:0] mul_a;
  logic [31:0] mul_b;
  logic        mul_done;
  logic [31:0] mul_res;
  logic        div_en;
  logic        div_fuct3;
  logic        div_signed;
  logic [31:0] div_a;
  logic [31:0] div_b;
  logic        div_done;
  logic [31:0] div_res;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        busy;

  int checks = 0;
  int errors = 0;

  int mulDelay = 0;
  int mulCnt;
  int mulEnCount;
  int divEnCount;
  int snapMul;
  int snapDiv;

  logic [63:0] product;

  muldiv_issue #(
    .XLEN(32),
    .RDW (5)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_funct3 (req_funct3),
    .req_rs1    (req_rs1),
    .req_rs2    (req_rs2),
    .req_rd     (req_rd),
    .flush      (flush),
    .mul_en     (mul_en),
    .mul_op     (mul_op),
    .mul_a      (mul_a),
    .mul_b      (mul_b),
    .mul_done   (mul_done),
    .mul_res    (mul_res),
    .div_en     (div_en),
    .div_fuct3  (div_fuct3),
    .div_signed (div_signed),
    .div_a      (div_a),
    .div_b      (div_b),
    .div_done   (div_done),
    .div_res    (div_res),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_data   (rsp_data),
    .rsp_rd     (rsp_rd),
    .busy       (busy)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier stub: done rises after mulDelay enabled cycles, and
  // enable-cycle counters let the bench measure how long each unit ran.
  always @(posedge clk) begin
    mulCnt     <= mul_en ? mulCnt + 1 : 0;
    mulEnCount <= mulEnCount + (mul_en ? 1 : 0);
    divEnCount <= divEnCount + (div_en ? 1 : 0);
  end

  initial begin
    mulCnt     = 0;
    mulEnCount = 0;
    divEnCount = 0;
  end

  assign mul_done = mul_en && (mulCnt >= mulDelay);
  assign div_done = div_en;

  // Multiplier stub result: 64-bit product of sign/zero-extended operands
  always_comb begin
    product = 64'd0;
    mul_res = 32'd0;
    case (mul_op)
      2'b00: begin product = {32'd0, mul_a} * {32'd0, mul_b}; mul_res = product[31:0]; end
      2'b01: begin product = {{32{mul_a[31]}}, mul_a} * {{32{mul_b[31]}}, mul_b}; mul_res = product[63:32]; end
      2'b10: begin product = {{32{mul_a[31]}}, mul_a} * {32'd0, mul_b}; mul_res = product[63:32]; end
      default: begin product = {32'd0, mul_a} * {32'd0, mul_b}; mul_res = product[63:32]; end
    endcase
  end

  // Divider stub result
  always_comb begin
    div_res = 32'd0;
    if (div_b != 32'd0) begin
      if (div_signed)
        div_res = div_fuct3 ? 32'($signed(div_a) / $signed(div_b)) : 32'($signed(div_a) % $signed(div_b));
      else
        div_res = div_fuct3 ? (div_a / div_b) : (div_a % div_b);
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks = checks + 1;
    if (observed !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Offer one op and return 1ns after the accept edge
  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    req_valid  = 1'b1;
    req_funct3 = f3;
    req_rs1    = a;
    req_rs2    = b;
    req_rd     = rd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic stepCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic drainResponse;
    rsp_ready = 1'b1;
    stepCycle();
    rsp_ready = 1'b0;
  endtask

  initial begin
    rst_n      = 1'b0;
    req_valid  = 1'b0;
    req_funct3 = 3'd0;
    req_rs1    = 32'd0;
    req_rs2    = 32'd0;
    req_rd     = 5'd0;
    flush      = 1'b0;
    rsp_ready  = 1'b0;

    $display("[TB] reset");
    stepCycle();
    stepCycle();
    checkOutput("rst_rsp_valid", rsp_valid, 0);
    checkOutput("rst_busy", busy, 0);
    checkOutput("rst_mul_en", mul_en, 0);
    checkOutput("rst_div_en", div_en, 0);
    checkOutput("rst_rsp_data", rsp_data, 0);
    checkOutput("rst_rsp_rd", rsp_rd, 0);
    checkOutput("rst_req_ready", req_ready, 1);
    rst_n = 1'b1;
    stepCycle();

    $display("[TB] DIV -7 / 2");
    snapDiv = divEnCount;
    applyStimulus(3'b100, 32'hFFFF_FFF9, 32'd2, 5'd3);
    checkOutput("div_en_wait", div_en, 1);
    checkOutput("div_signed", div_signed, 1);
    checkOutput("div_fuct3", div_fuct3, 1);
    checkOutput("div_a", div_a, 32'hFFFF_FFF9);
    checkOutput("div_valid_early", rsp_valid, 0);
    stepCycle();
    checkOutput("div_valid", rsp_valid, 1);
    checkOutput("div_data", rsp_data, 32'hFFFF_FFFD);
    checkOutput("div_rd", rsp_rd, 3);
    checkOutput("div_en_after", div_en, 0);
    checkOutput("div_en_cycles", divEnCount - snapDiv, 1);
    drainResponse();
    checkOutput("div_idle", busy, 0);

    $display("[TB] divide by zero");
    snapDiv = divEnCount;
    applyStimulus(3'b111, 32'd5, 32'd0, 5'd7);
    checkOutput("remu0_valid", rsp_valid, 1);
    checkOutput("remu0_data", rsp_data, 5);
    checkOutput("remu0_rd", rsp_rd, 7);
    checkOutput("remu0_div_en", div_en, 0);
    drainResponse();
    applyStimulus(3'b101, 32'd9, 32'd0, 5'd8);
    checkOutput("divu0_data", rsp_data, 32'hFFFF_FFFF);
    drainResponse();
    checkOutput("div0_no_en", divEnCount - snapDiv, 0);

    $display("[TB] signed overflow");
    snapDiv = divEnCount;
    applyStimulus(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd4);
    checkOutput("ovf_div_valid", rsp_valid, 1);
    checkOutput("ovf_div_data", rsp_data, 32'h8000_0000);
    drainResponse();
    applyStimulus(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd5);
    checkOutput("ovf_rem_data", rsp_data, 0);
    drainResponse();
    checkOutput("ovf_no_en", divEnCount - snapDiv, 0);
    applyStimulus(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd6);
    checkOutput("ovf_divu_en", div_en, 1);
    checkOutput("ovf_divu_signed", div_signed, 0);
    stepCycle();
    checkOutput("ovf_divu_data", rsp_data, 0);
    drainResponse();

    $display("[TB] MULHU with slow multiplier and stalled writeback");
    mulDelay = 3;
    snapMul = mulEnCount;
    applyStimulus(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd9);
    for (int i = 0; i < 4; i++) begin
      checkOutput("mulhu_en", mul_en, 1);
      checkOutput("mulhu_op", mul_op, 3);
      checkOutput("mulhu_ready", req_ready, 0);
      checkOutput("mulhu_nvalid", rsp_valid, 0);
      stepCycle();
    end
    req_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("mulhu_valid", rsp_valid, 1);
      checkOutput("mulhu_data", rsp_data, 32'hFFFF_FFFE);
      checkOutput("mulhu_rd", rsp_rd, 9);
      checkOutput("mulhu_hold_ready", req_ready, 0);
      if (i < 3) stepCycle();
    end
    checkOutput("mulhu_en_cycles", mulEnCount - snapMul, 4);
    drainResponse();
    checkOutput("mulhu_no_same_accept", busy, 0);
    req_valid = 1'b0;
    mulDelay = 0;

    $display("[TB] MUL low word");
    applyStimulus(3'b000, 32'd6, 32'd7, 5'd10);
    checkOutput("mul_en", mul_en, 1);
    stepCycle();
    checkOutput("mul_data", rsp_data, 42);
    drainResponse();

    $display("[TB] flush with done");
    applyStimulus(3'b101, 32'd100, 32'd7, 5'd11);
    checkOutput("flush_div_done", div_done, 1);
    flush = 1'b1;
    stepCycle();
    flush = 1'b0;
    checkOutput("flush_busy", busy, 0);
    checkOutput("flush_valid", rsp_valid, 0);
    stepCycle();
    checkOutput("flush_valid_later", rsp_valid, 0);

    $display("[TB] flush in idle");
    req_valid  = 1'b1;
    req_funct3 = 3'b000;
    flush      = 1'b1;
    #1;
    checkOutput("flush_idle_ready", req_ready, 0);
    stepCycle();
    req_valid = 1'b0;
    flush     = 1'b0;
    checkOutput("flush_idle_busy", busy, 0);

    $display("[TB] reset mid response");
    applyStimulus(3'b111, 32'd5, 32'd0, 5'd7);
    checkOutput("mid_valid", rsp_valid, 1);
    rst_n = 1'b0;
    stepCycle();
    checkOutput("mid_rst_valid", rsp_valid, 0);
    checkOutput("mid_rst_busy", busy, 0);
    checkOutput("mid_rst_data", rsp_data, 0);
    checkOutput("mid_rst_rd", rsp_rd, 0);
    checkOutput("mid_rst_mul_a", mul_a, 0);
    checkOutput("mid_rst_div_a", div_a, 0);
    checkOutput("mid_rst_div_fuct3", div_fuct3, 0);
    checkOutput("mid_rst_div_signed", div_signed, 0);
    rst_n = 1'b1;
    applyStimulus(3'b000, 32'd3, 32'd5, 5'd12);
    stepCycle();
    checkOutput("post_rst_valid", rsp_valid, 1);
    checkOutput("post_rst_data", rsp_data, 15);
    checkOutput("post_rst_rd", rsp_rd, 12);
    drainResponse();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
